// File: rtl/expr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : expr_pkg
// Brief    : Shared operator codes, switch-word layout and FSM encoding for the
//            keypad-token transmitter.
// Revision : 1.0  initial release
// ============================================================================
package expr_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Consumer switch-word layout; bit 3 is unused and driven low
  localparam int SW_W      = 6;
  localparam int SW_MAG_LO = 0;
  localparam int SW_MAG_HI = 1;
  localparam int SW_NEG    = 2;
  localparam int SW_OP_LO  = 4;
  localparam int SW_OP_HI  = 5;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_PULSE = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef struct packed {
    logic [1:0] op;
    logic       neg;
    logic [1:0] mag;
  } entry_t;

  function automatic logic [SW_W-1:0] make_sw(entry_t ent, logic last);
    logic [SW_W-1:0] sw;
    sw                       = '0;
    sw[SW_MAG_HI:SW_MAG_LO]  = ent.mag;
    sw[SW_NEG]               = ent.neg;
    sw[SW_OP_HI:SW_OP_LO]    = last ? OP_ADD : ent.op;
    return sw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/strobe_timer.sv
`default_nettype none
// ============================================================================
// Module   : strobe_timer
// Brief    : Loadable down-counter that saturates at zero; tc flags zero.
// Revision : 1.0  initial release
// ============================================================================
module strobe_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign tc = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/expr_token_tx.sv
`default_nettype none
// ============================================================================
// Module   : expr_token_tx
// Brief    : Buffers operand/operator entries and replays them as timed
//            switch-word + key-strobe tokens for the arithmetic unit.
// Revision : 1.0  initial release
// ============================================================================
module expr_token_tx
  import expr_pkg::*;
#(
  parameter int N_OPERANDS   = 5,
  parameter int GAP_CYCLES   = 4,
  parameter int PULSE_CYCLES = 2
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [1:0] load_mag,
  input  logic       load_neg,
  input  logic [1:0] load_op,
  input  logic       clear,
  input  logic       start,
  input  logic       tok_ready,
  output logic [5:0] tok_sw,
  output logic       tok_strobe,
  output logic [2:0] tok_index,
  output logic       busy,
  output logic       done
);

  localparam int              TMR_MAX  = (GAP_CYCLES > PULSE_CYCLES) ? GAP_CYCLES : PULSE_CYCLES;
  localparam int              TMR_W    = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [2:0]      N_MAX    = 3'(N_OPERANDS);

  logic [2:0]       r_state;
  logic [2:0]       r_count;
  logic [2:0]       r_idx;
  logic [SW_W-1:0]  r_sw;
  entry_t           r_mem [N_OPERANDS];

  logic             w_idle;
  logic             w_load_fire;
  logic             w_start_fire;
  logic             w_mem_we;
  logic [2:0]       w_next_idx;
  logic             w_more;
  logic             w_next_last;
  entry_t           w_load_ent;
  logic             w_tc;
  logic             w_tmr_load;
  logic             w_tmr_en;
  logic [TMR_W-1:0] w_tmr_val;

  assign w_idle       = (r_state == ST_IDLE);
  assign load_ready   = w_idle && (r_count < N_MAX);
  assign w_load_fire  = load_valid && load_ready;
  assign w_mem_we     = w_load_fire && !clear && !RST;
  assign w_start_fire = w_idle && start && !clear && (r_count != 3'd0);
  assign w_next_idx   = r_idx + 3'd1;
  assign w_more       = (w_next_idx < r_count);
  assign w_next_last  = ((r_idx + 3'd2) == r_count);

  // A signed zero is meaningless to the consumer, so it is normalised to +0
  assign w_load_ent.mag = load_mag;
  assign w_load_ent.neg = load_neg && (load_mag != 2'd0);
  assign w_load_ent.op  = load_op;

  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = GAP_LD;
    w_tmr_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tmr_load = w_start_fire;
      end
      ST_SETUP: begin
        w_tmr_en = 1'b1;
        if (w_tc && tok_ready) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = PULSE_LD;
        end
      end
      ST_PULSE: begin
        w_tmr_en   = 1'b1;
        w_tmr_load = w_tc;
      end
      ST_HOLD: begin
        w_tmr_en   = 1'b1;
        w_tmr_load = w_tc && w_more;
      end
      default: begin
        w_tmr_load = 1'b0;
      end
    endcase
  end

  strobe_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk      (CLOCK_50),
    .rst      (RST),
    .load     (w_tmr_load),
    .load_val (w_tmr_val),
    .en       (w_tmr_en),
    .tc       (w_tc)
  );

  always_ff @(posedge CLOCK_50) begin
    if (w_mem_we) begin
      r_mem[r_count] <= w_load_ent;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_count <= 3'd0;
      r_idx   <= 3'd0;
      r_sw    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clear) begin
            r_count <= 3'd0;
          end else begin
            if (w_load_fire) begin
              r_count <= r_count + 3'd1;
            end
            if (w_start_fire) begin
              r_state <= ST_SETUP;
              r_idx   <= 3'd0;
              r_sw    <= make_sw(r_mem[0], r_count == 3'd1);
            end
          end
        end
        ST_SETUP: begin
          if (w_tc && tok_ready) begin
            r_state <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (w_tc) begin
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // tok_sw only ever changes here, on entry to the next SETUP
          if (w_tc) begin
            if (w_more) begin
              r_state <= ST_SETUP;
              r_idx   <= w_next_idx;
              r_sw    <= make_sw(r_mem[w_next_idx], w_next_last);
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tok_sw     = r_sw;
  assign tok_index  = r_idx;
  assign tok_strobe = (r_state == ST_PULSE);
  assign busy       = (r_state == ST_SETUP) || (r_state == ST_PULSE) || (r_state == ST_HOLD);
  assign done       = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_expr_token_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_expr_token_tx
// Brief    : Directed self-checking bench for expr_token_tx.
// Revision : 1.0  initial release
// ============================================================================
module tb_expr_token_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [1:0] load_mag = 2'd0;
  logic       load_neg = 1'b0;
  logic [1:0] load_op = 2'd0;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  logic       tok_ready = 1'b1;
  logic [5:0] tok_sw;
  logic       tok_strobe;
  logic [2:0] tok_index;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  expr_token_tx #(
    .N_OPERANDS   (5),
    .GAP_CYCLES   (4),
    .PULSE_CYCLES (2)
  ) dut (
    .CLOCK_50   (clk),
    .RST        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_mag   (load_mag),
    .load_neg   (load_neg),
    .load_op    (load_op),
    .clear      (clear),
    .start      (start),
    .tok_ready  (tok_ready),
    .tok_sw     (tok_sw),
    .tok_strobe (tok_strobe),
    .tok_index  (tok_index),
    .busy       (busy),
    .done       (done)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t_start = 0;

  always @(posedge clk) cyc <= cyc + 1;

  int         rise_cyc [64];
  logic [5:0] rise_sw  [64];
  logic [2:0] rise_idx [64];
  int         n_rise = 0;
  int         n_done = 0;
  int         done_long = 0;
  int         sw_glitch = 0;
  int         hi_len = 0;
  int         last_width = 0;
  logic       prev_strobe = 1'b0;
  logic       prev_done = 1'b0;
  logic [5:0] prev_sw = 6'd0;

  // Token monitor: strobe rises, pulse widths, done pulses, sw changes under strobe
  always @(negedge clk) begin
    if (tok_strobe && !prev_strobe && n_rise < 64) begin
      rise_cyc[n_rise] <= cyc;
      rise_sw[n_rise]  <= tok_sw;
      rise_idx[n_rise] <= tok_index;
      n_rise           <= n_rise + 1;
    end
    if (tok_strobe) begin
      hi_len <= hi_len + 1;
    end else begin
      if (prev_strobe) last_width <= hi_len;
      hi_len <= 0;
    end
    if (tok_strobe && prev_strobe && tok_sw != prev_sw) sw_glitch <= sw_glitch + 1;
    if (done) n_done <= n_done + 1;
    if (done && prev_done) done_long <= done_long + 1;
    prev_strobe <= tok_strobe;
    prev_done   <= done;
    prev_sw     <= tok_sw;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_entry(input logic [1:0] m, input logic n, input logic [1:0] o);
    load_mag   = m;
    load_neg   = n;
    load_op    = o;
    load_valid = 1'b1;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  task automatic start_pulse();
    @(posedge clk);
    #1;
    t_start = cyc;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int base;
    int k;
    base = n_done;
    k    = 0;
    while (n_done == base && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", 32'(n_done != base), 32'd1);
  endtask

  task automatic wait_rises(input int target, input int limit);
    int k;
    k = 0;
    while (n_rise < target && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("rise_seen", 32'(n_rise >= target), 32'd1);
  endtask

  logic [5:0] exp_sw [5];
  int         rb;
  int         nd0;
  logic       stable;

  initial begin
    exp_sw[0] = 6'h01;
    exp_sw[1] = 6'h26;
    exp_sw[2] = 6'h13;
    exp_sw[3] = 6'h30;
    exp_sw[4] = 6'h02;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tok_sw", tok_sw, 6'h00);
    chk("rst_strobe", tok_strobe, 1'b0);
    chk("rst_index", tok_index, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_load_ready", load_ready, 1'b1);

    // Five-entry expression, then a sixth entry that must be dropped
    load_entry(2'd1, 1'b0, 2'b00);
    load_entry(2'd2, 1'b1, 2'b10);
    load_entry(2'd3, 1'b0, 2'b01);
    load_entry(2'd0, 1'b0, 2'b11);
    load_entry(2'd2, 1'b0, 2'b00);
    @(negedge clk);
    chk("full_load_ready", load_ready, 1'b0);
    load_entry(2'd3, 1'b1, 2'b11);

    rb  = n_rise;
    nd0 = n_done;
    start_pulse();
    @(negedge clk);
    chk("start_busy", busy, 1'b1);
    chk("start_tok_sw", tok_sw, 6'h01);
    chk("start_index", tok_index, 3'd0);
    wait_done(200);
    chk("run1_rises", n_rise - rb, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("run1_sw%0d", i), rise_sw[rb+i], exp_sw[i]);
    chk("run1_first_rise", rise_cyc[rb] - t_start, 5);
    for (int i = 1; i < 5; i++) chk($sformatf("run1_period%0d", i), rise_cyc[rb+i] - rise_cyc[rb+i-1], 10);
    chk("run1_last_index", rise_idx[rb+4], 3'd4);
    chk("pulse_width", last_width, 2);
    chk("done_count", n_done - nd0, 1);
    chk("done_one_cycle", done_long, 0);
    chk("after_done_busy", busy, 1'b0);
    chk("after_done_done", done, 1'b0);
    chk("after_done_ready", load_ready, 1'b0);

    // Re-replay of the retained buffer
    rb = n_rise;
    start_pulse();
    wait_done(200);
    chk("run2_rises", n_rise - rb, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("run2_sw%0d", i), rise_sw[rb+i], exp_sw[i]);
    chk("run2_first_rise", rise_cyc[rb] - t_start, 5);

    // Consumer back-pressure: 7 extra cycles of tok_ready low after the gap
    tok_ready = 1'b0;
    rb        = n_rise;
    start_pulse();
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (tok_sw !== 6'h01 || tok_strobe !== 1'b0) stable = 1'b0;
      @(posedge clk);
    end
    #1;
    tok_ready = 1'b1;
    chk("ready_low_stable", stable, 1'b1);
    wait_done(200);
    chk("run3_rises", n_rise - rb, 5);
    chk("run3_first_rise", rise_cyc[rb] - t_start, 12);
    chk("run3_period", rise_cyc[rb+1] - rise_cyc[rb], 10);
    chk("run3_sw0", rise_sw[rb], 6'h01);
    chk("sw_stable_under_strobe", sw_glitch, 0);

    // Reset during the third token's pulse
    rb = n_rise;
    start_pulse();
    wait_rises(rb + 3, 100);
    chk("rst_mid_in_pulse", tok_strobe, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_strobe", tok_strobe, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_ready", load_ready, 1'b1);
    chk("rst_mid_index", tok_index, 3'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_pulse();
    @(negedge clk);
    chk("start_empty_busy", busy, 1'b0);
    repeat (8) @(negedge clk);
    chk("start_empty_no_rise", n_rise - rb, 3);

    // Negative zero is stored as positive zero
    load_entry(2'd0, 1'b1, 2'b01);
    load_entry(2'd1, 1'b0, 2'b00);
    rb = n_rise;
    start_pulse();
    @(negedge clk);
    chk("neg_zero_sw", tok_sw, 6'h10);
    wait_done(100);
    chk("neg_zero_rises", n_rise - rb, 2);
    chk("neg_zero_second_sw", rise_sw[rb+1], 6'h01);

    // Simultaneous clear and start in IDLE: clear wins
    load_entry(2'd3, 1'b0, 2'b00);
    clear = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("clear_start_busy", busy, 1'b0);
    chk("clear_start_ready", load_ready, 1'b1);
    start_pulse();
    @(negedge clk);
    chk("start_after_clear_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
